// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared mode encoding and mode sequencing for the time-of-day controller
package clock_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  // The unused encoding 3 behaves like RUN, so it also advances to SET_HOUR.
  function automatic mode_e mode_step(input mode_e m);
    return m == MODE_SET_HOUR ? MODE_SET_MIN : m == MODE_SET_MIN ? MODE_RUN : MODE_SET_HOUR;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronize an active-low key, accept stable levels, pulse once per accepted press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);
  logic s0, s1, level, armed;
  logic [1:0] vld;
  logic [CW-1:0] cnt;
  // Presses are armed only after a genuine released sample (vld marks s1 as real data), so a key held through reset stays silent.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      {s0, s1, level, armed, press} <= '0;
      vld <= '0;
      cnt <= '0;
    end else begin
      s0 <= ~key_n;
      s1 <= s0;
      vld <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & ~s1);
      press <= 1'b0;
      if (s1 == level) cnt <= '0;
      else if (cnt == LAST) begin
        cnt <= '0;
        level <= s1;
        press <= s1 & armed;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: one-second prescaler, RUN/SET_HOUR/SET_MIN mode machine and display gating
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICKS_PER_SEC   = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  output logic       sec_tick,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       sec_clear,
  output logic [1:0] mode,
  output logic       disp_en_hours,
  output logic       disp_en_minutes,
  output logic       dot
);
  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] HALF = CW'(TICKS_PER_SEC / 2);
  mode_e mode_q, mode_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic press_mode, press_inc, tick_nx, min_nx, hour_nx, clear_nx, blink_on, setting;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clock(clock), .reset(reset), .key_n(key_mode_n), .press(press_mode)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clock(clock), .reset(reset), .key_n(key_inc_n), .press(press_inc)
  );

  // State register: mode, prescaler and all registered pulses.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mode_q <= MODE_RUN;
      cnt <= '0;
      {sec_tick, min_inc, hour_inc, sec_clear} <= '0;
    end else begin
      mode_q <= mode_nx;
      cnt <= cnt_nx;
      {sec_tick, min_inc, hour_inc, sec_clear} <= {tick_nx, min_nx, hour_nx, clear_nx};
    end

  // Next state: mode steps on a mode press; prescaler wraps, restarting a full second on return to RUN.
  always_comb begin
    mode_nx = press_mode ? mode_step(mode_q) : mode_q;
    cnt_nx = (press_mode && mode_q == MODE_SET_MIN) ? '0 : cnt == LAST ? '0 : cnt + CW'(1);
  end

  // Outputs: pulse next-values (a mode press wins over an inc press) and display gating from registered state.
  always_comb begin
    tick_nx = mode_nx != MODE_SET_HOUR && mode_nx != MODE_SET_MIN && cnt_nx == LAST;
    hour_nx = press_inc && !press_mode && mode_q == MODE_SET_HOUR;
    min_nx = press_inc && !press_mode && mode_q == MODE_SET_MIN;
    clear_nx = press_mode && mode_q == MODE_SET_MIN;
    blink_on = cnt < HALF;
    setting = mode_q == MODE_SET_HOUR || mode_q == MODE_SET_MIN;
    disp_en_hours = mode_q == MODE_SET_HOUR ? blink_on : 1'b1;
    disp_en_minutes = mode_q == MODE_SET_MIN ? blink_on : 1'b1;
    dot = setting ? 1'b1 : blink_on;
  end

  assign mode = mode_q;
endmodule
